// File: rtl/pc_sequencer.sv
// Program counter sequencer with an optional return-address stack (RAS).
// Define PC_SEQUENCER_RAS_EN to build the RAS in; otherwise CALL and return-select are inert.
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] INTR_VEC  = '1,
    localparam int unsigned      CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_LD,
    input  logic              PC_INC,
    input  logic [1:0]        PC_MUX_SEL,
    input  logic [ADDR_W-1:0] IR,
    input  logic [ADDR_W-1:0] DATA_OUT,
    input  logic              CALL,
    output logic [ADDR_W-1:0] PC_COUNT,
    output logic              RAS_FULL,
    output logic              RAS_EMPTY,
    output logic              RAS_ERR,
    output logic [CNT_W-1:0]  RAS_CNT
);

    typedef enum logic [1:0] {
        SEL_IR   = 2'd0,
        SEL_DATA = 2'd1,
        SEL_VEC  = 2'd2,
        SEL_RAS  = 2'd3
    } pc_sel_e;

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1;

    assign sel      = pc_sel_e'(PC_MUX_SEL);
    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign PC_COUNT = pc_q;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int unsigned IDX_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              at_full;
    logic              at_empty;

    assign at_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign at_empty = (cnt_q == '0);
    assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = IDX_W'(cnt_q);
        if (PC_LD) begin
            unique case (sel)
                SEL_IR:   pc_d = IR;
                SEL_DATA: pc_d = DATA_OUT;
                SEL_VEC:  pc_d = INTR_VEC;
                SEL_RAS: begin
                    if (at_empty) begin
                        pc_d  = INTR_VEC;
                        err_d = 1'b1;
                    end else begin
                        pc_d = ras_q[top_idx];
                        // Call through a return swaps the top entry in place, occupancy unchanged.
                        if (CALL) begin
                            wr_en  = 1'b1;
                            wr_idx = top_idx;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: pc_d = pc_q;
            endcase
            if (CALL && (sel != SEL_RAS)) begin
                if (at_full) begin
                    err_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (PC_INC) begin
            pc_d = pc_plus1;
        end
    end

    always_comb begin
        full_d  = (cnt_d == CNT_W'(RAS_DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Entry storage is not reset; occupancy gating keeps stale entries unreachable.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            ras_q[wr_idx] <= pc_plus1;
        end
    end

    assign RAS_CNT   = cnt_q;
    assign RAS_ERR   = err_q;
    assign RAS_FULL  = full_q;
    assign RAS_EMPTY = empty_q;
`else
    logic unused_call;
    assign unused_call = CALL;

    always_comb begin
        pc_d = pc_q;
        if (PC_LD) begin
            unique case (sel)
                SEL_IR:   pc_d = IR;
                SEL_DATA: pc_d = DATA_OUT;
                SEL_VEC:  pc_d = INTR_VEC;
                SEL_RAS:  pc_d = pc_q;
                default:  pc_d = pc_q;
            endcase
        end else if (PC_INC) begin
            pc_d = pc_plus1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign RAS_CNT   = '0;
    assign RAS_ERR   = 1'b0;
    assign RAS_FULL  = 1'b0;
    assign RAS_EMPTY = 1'b1;
`endif

endmodule
